icache_line_fill: RTL

// - Fill engine directly upstream of the ICACHE_INS1 SDPRAM (1024x32) write port.
// - On an I-cache miss it fetches one aligned line from backing memory and writes each beat into the RAM.
// - After reset or flush_req it clears the RAM by writing zeros to every entry.
// - Reports fill completion or error to the cache controller.

---
 rtl/icache_pkg.sv | 26 ++
 rtl/icache_line_fill.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_pkg.sv
// Shared types and helpers for the I-cache line fill engine.
package icache_pkg;

    localparam int DEF_WR_ADDR_WIDTH  = 10;
    localparam int DEF_WR_DATA_WIDTH  = 32;
    localparam int DEF_LINE_WORDS     = 8;
    localparam int DEF_MEM_ADDR_WIDTH = 32;
    localparam int LINE_OFS_W         = $clog2(DEF_LINE_WORDS);
    localparam int IDX_W              = DEF_WR_ADDR_WIDTH - LINE_OFS_W;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_REQ   = 2'd2,
        ST_DATA  = 2'd3
    } fill_state_e;

    // Clears the byte offset of a word-organised line of line_words words.
    function automatic logic [63:0] line_align(input logic [63:0] addr,
                                               input int unsigned line_words);
        logic [63:0] ofs_mask;
        ofs_mask = (64'(line_words) * 64'd4) - 64'd1;
        return addr & ~ofs_mask;
    endfunction

endpackage

// File: rtl/icache_line_fill.sv
// Line fill engine in front of the I-cache RAM write port: fetches a line on a miss
// and sweeps the RAM to zero after reset or a flush.
module icache_line_fill
    import icache_pkg::*;
#(
    parameter int WR_ADDR_WIDTH  = DEF_WR_ADDR_WIDTH,
    parameter int WR_DATA_WIDTH  = DEF_WR_DATA_WIDTH,
    parameter int LINE_WORDS     = DEF_LINE_WORDS,
    parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                          wr_clk,
    input  logic                                          tb_wr_rst,
    input  logic                                          flush_req,
    input  logic                                          miss_valid,
    output logic                                          miss_ready,
    input  logic [MEM_ADDR_WIDTH-1:0]                     miss_addr,
    output logic                                          mem_req_valid,
    input  logic                                          mem_req_ready,
    output logic [MEM_ADDR_WIDTH-1:0]                     mem_req_addr,
    output logic [7:0]                                    mem_req_len,
    input  logic                                          mem_rvalid,
    input  logic [WR_DATA_WIDTH-1:0]                      mem_rdata,
    input  logic                                          mem_rlast,
    input  logic                                          mem_rerr,
    output logic                                          ram_wr_en,
    output logic [WR_ADDR_WIDTH-1:0]                      ram_wr_addr,
    output logic [WR_DATA_WIDTH-1:0]                      ram_wr_data,
    output logic                                          fill_done,
    output logic                                          fill_err,
    output logic [WR_ADDR_WIDTH-$clog2(LINE_WORDS)-1:0]   fill_idx,
    output logic                                          busy
);

    localparam int OFS_W = $clog2(LINE_WORDS);
    localparam int IX_W  = WR_ADDR_WIDTH - OFS_W;
    localparam logic [OFS_W-1:0]       BEAT_LAST = OFS_W'(LINE_WORDS - 1);
    localparam logic [OFS_W-1:0]       BEAT_ONE  = OFS_W'(1);
    localparam logic [WR_ADDR_WIDTH:0] CLR_ONE   = (WR_ADDR_WIDTH + 1)'(1);
    localparam logic [7:0]             REQ_LEN   = 8'(LINE_WORDS - 1);
    localparam fill_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    fill_state_e                state_r, state_s;
    logic [WR_ADDR_WIDTH:0]     clr_cnt_r, clr_cnt_s;
    logic [OFS_W-1:0]           beat_cnt_r, beat_cnt_s;
    logic                       drain_r, drain_s;
    logic                       flush_pend_r, flush_pend_s;
    logic                       idle_r;
    logic                       busy_r;
    logic                       req_valid_r;
    logic [7:0]                 req_len_r;
    logic [MEM_ADDR_WIDTH-1:0]  req_addr_r, req_addr_s;
    logic [IX_W-1:0]            fill_idx_r, fill_idx_s;
    logic                       wr_en_r, wr_en_s;
    logic [WR_ADDR_WIDTH-1:0]   wr_addr_r, wr_addr_s;
    logic [WR_DATA_WIDTH-1:0]   wr_data_r, wr_data_s;
    logic                       done_r, done_s;
    logic                       err_r, err_s;
    logic                       miss_ready_s;
    logic                       beat_bad_s;

    // A flush in the same cycle wins over a presented miss, so ready drops at once.
    assign miss_ready_s = idle_r & ~flush_pend_r & ~flush_req;
    assign beat_bad_s   = mem_rerr | (mem_rlast != (beat_cnt_r == BEAT_LAST));

    // Next-state and next-output logic for the clear / fill sequencer.
    always_comb begin
        state_s      = state_r;
        clr_cnt_s    = clr_cnt_r;
        beat_cnt_s   = beat_cnt_r;
        drain_s      = drain_r;
        flush_pend_s = flush_pend_r;
        req_addr_s   = req_addr_r;
        fill_idx_s   = fill_idx_r;
        wr_en_s      = 1'b0;
        wr_addr_s    = wr_addr_r;
        wr_data_s    = wr_data_r;
        done_s       = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                flush_pend_s = 1'b0;
                if (clr_cnt_r[WR_ADDR_WIDTH]) begin
                    state_s = ST_IDLE;
                end else begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = clr_cnt_r[WR_ADDR_WIDTH-1:0];
                    wr_data_s = {WR_DATA_WIDTH{1'b0}};
                    clr_cnt_s = clr_cnt_r + CLR_ONE;
                end
            end
            ST_IDLE: begin
                if (flush_req || flush_pend_r) begin
                    state_s      = ST_CLEAR;
                    clr_cnt_s    = {(WR_ADDR_WIDTH + 1){1'b0}};
                    flush_pend_s = 1'b0;
                end else if (miss_valid && miss_ready_s) begin
                    state_s    = ST_REQ;
                    req_addr_s = MEM_ADDR_WIDTH'(line_align(64'(miss_addr), LINE_WORDS));
                    fill_idx_s = miss_addr[OFS_W+2 +: IX_W];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (flush_req) begin
                    flush_pend_s = 1'b1;
                end else begin
                    flush_pend_s = flush_pend_r;
                end
                if (mem_req_ready) begin
                    state_s    = ST_DATA;
                    beat_cnt_s = {OFS_W{1'b0}};
                    drain_s    = 1'b0;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DATA: begin
                if (flush_req) begin
                    flush_pend_s = 1'b1;
                end else begin
                    flush_pend_s = flush_pend_r;
                end
                // The final write is on the outputs now; leave only after it retires.
                if (done_r) begin
                    state_s = ST_IDLE;
                end else if (!mem_rvalid) begin
                    state_s = ST_DATA;
                end else if (drain_r) begin
                    if (mem_rlast) begin
                        state_s = ST_IDLE;
                        drain_s = 1'b0;
                    end else begin
                        drain_s = 1'b1;
                    end
                end else if (beat_bad_s) begin
                    err_s = 1'b1;
                    if (mem_rlast) begin
                        state_s = ST_IDLE;
                    end else begin
                        drain_s = 1'b1;
                    end
                end else begin
                    wr_en_s    = 1'b1;
                    wr_addr_s  = {fill_idx_r, beat_cnt_r};
                    wr_data_s  = mem_rdata;
                    beat_cnt_s = beat_cnt_r + BEAT_ONE;
                    done_s     = mem_rlast;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state_r      <= RST_STATE;
            clr_cnt_r    <= {(WR_ADDR_WIDTH + 1){1'b0}};
            beat_cnt_r   <= {OFS_W{1'b0}};
            drain_r      <= 1'b0;
            flush_pend_r <= 1'b0;
            idle_r       <= 1'b0;
            busy_r       <= 1'b0;
            req_valid_r  <= 1'b0;
            req_len_r    <= 8'd0;
            req_addr_r   <= {MEM_ADDR_WIDTH{1'b0}};
            fill_idx_r   <= {IX_W{1'b0}};
            wr_en_r      <= 1'b0;
            wr_addr_r    <= {WR_ADDR_WIDTH{1'b0}};
            wr_data_r    <= {WR_DATA_WIDTH{1'b0}};
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            clr_cnt_r    <= clr_cnt_s;
            beat_cnt_r   <= beat_cnt_s;
            drain_r      <= drain_s;
            flush_pend_r <= flush_pend_s;
            idle_r       <= (state_s == ST_IDLE);
            busy_r       <= (state_s != ST_IDLE);
            req_valid_r  <= (state_s == ST_REQ);
            req_len_r    <= REQ_LEN;
            req_addr_r   <= req_addr_s;
            fill_idx_r   <= fill_idx_s;
            wr_en_r      <= wr_en_s;
            wr_addr_r    <= wr_addr_s;
            wr_data_r    <= wr_data_s;
            done_r       <= done_s;
            err_r        <= err_s;
        end
    end

    assign miss_ready    = miss_ready_s;
    assign mem_req_valid = req_valid_r;
    assign mem_req_addr  = req_addr_r;
    assign mem_req_len   = req_len_r;
    assign ram_wr_en     = wr_en_r;
    assign ram_wr_addr   = wr_addr_r;
    assign ram_wr_data   = wr_data_r;
    assign fill_done     = done_r;
    assign fill_err      = err_r;
    assign fill_idx      = fill_idx_r;
    assign busy          = busy_r;

endmodule
